alu_pipe_core: RTL and testbench
================================

ALU_PIPE_CORE -- requirements
Module: alu_pipe_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal range 4..32.
REQ-002 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  operation request present.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 The block SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-007 The block SHALL have port acc_sel  input  1  1 = operand A taken from the held result register instead of a.
REQ-008 The block SHALL have port a  input  WIDTH  operand A.
REQ-009 The block SHALL have port b  input  WIDTH  operand B.
REQ-010 The block SHALL have port cin  input  1  carry in, used by ADD only.
REQ-011 The block SHALL have port out_valid  output  1  result/flags valid.
REQ-012 The block SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-013 The block SHALL have port result  output  WIDTH  result, low half of product for MUL.
REQ-014 The block SHALL have port result_hi  output  WIDTH  high half of product for MUL, 0 for all other ops.
REQ-015 The block SHALL have port flags  output  4  {V,N,Z,C}, bit 3 = V.

Function
REQ-016 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; op, a, b, cin, acc_sel sampled at that edge.
REQ-017 in_ready SHALL equal (state == IDLE) and (out_valid == 0 or out_ready == 1), giving one op/cycle throughput for non-MUL ops.
REQ-018 Non-MUL ops SHALL have latency 1: out_valid asserted after the accepting edge with registered result and flags.
REQ-019 MUL SHALL be unsigned shift-add, one multiplier bit per cycle; state IDLE -> BUSY at accept, BUSY -> IDLE after WIDTH cycles; out_valid asserts exactly WIDTH edges after accept.
REQ-020 While BUSY, in_ready SHALL be 0; out_valid from the prior op remains until consumed.
REQ-021 out_valid SHALL drop after an edge with out_ready = 1 unless a new result is produced on that same edge; result, result_hi, flags SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-022 ADD: result = a + b + cin mod 2^WIDTH; C = carry out; V = signed overflow.
REQ-023 SUB: result = a + ~b + 1 (cin ignored); C = carry out (1 = no borrow); V = signed overflow.
REQ-024 AND/OR/XOR: bitwise; C = 0, V = 0.
REQ-025 SHL: result = a << 1, C = a[WIDTH-1]; SHR: logical, result = a >> 1, C = a[0]; V = 0.
REQ-026 MUL: {result_hi, result} = full 2*WIDTH product; C = (result_hi != 0); V = 0; Z over full product; N = result_hi[WIDTH-1].
REQ-027 For non-MUL ops Z = (result == 0), N = result[WIDTH-1].
REQ-028 With acc_sel = 1, operand A SHALL be the current result register value, even if not yet consumed (0 after reset).

Reset
REQ-029 When rst_n = 0 at a rising edge: state = IDLE, out_valid = 0, result = 0, result_hi = 0, flags = 0, multiplier datapath cleared.
REQ-030 in_ready SHALL be 0 during reset and 1 on the first cycle after rst_n returns high.
REQ-031 Reset during BUSY SHALL abort the multiply with no out_valid pulse.

Structure
REQ-032 Package alu_pkg SHALL hold the opcode enum, state enum {IDLE, BUSY}, and flag bit index constants.
REQ-033 The multiply datapath SHALL be a sub-module alu_mul_seq (start, busy, done, product), parametrised by WIDTH.

Verification (WIDTH = 8)
REQ-034 ADD a=0xFF b=0x01 cin=0 -> next cycle result 0x00, flags V0 N0 Z1 C1, out_valid 1.
REQ-035 SUB a=0x80 b=0x01 -> result 0x7F, V1 N0 Z0 C1.
REQ-036 MUL a=0xFF b=0xFF -> result 0x01, result_hi 0xFE, C1; out_valid exactly 8 edges after accept; in_ready 0 throughout BUSY.
REQ-037 ADD 5+3 with out_ready=0, then second request -> in_ready 0, result 0x08 stable; raise out_ready -> second request accepted same edge.
REQ-038 ADD a=5 b=3, consume, then ADD acc_sel=1 b=2 -> result 0x0A.
REQ-039 rst_n low 4 cycles into MUL -> no out_valid, all outputs 0, in_ready 1 on first cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, control states and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier retiring one multiplier bit per cycle.
// done is asserted on the cycle whose edge completes the last step; product then carries the final value.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy    = (cnt_q != '0);
  assign done    = (cnt_q == CW'(1));
  assign product = acc_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= b;
      cnt_q    <= CW'(WIDTH);
    end else if (busy) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe_core.sv
// Single-issue ALU: one-cycle logic/arith ops, WIDTH-cycle sequential multiply.
// States: IDLE = accepting requests | BUSY = multiply in progress, requests stalled.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  alu_state_e         state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic [3:0]         flags_q;

  alu_op_e            op_e;
  logic [WIDTH-1:0]   opa;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic [3:0]         alu_flags;
  logic [3:0]         mul_flags;
  logic               c_bit;
  logic               v_bit;

  assign op_e      = alu_op_e'(op);
  assign opa       = acc_sel ? result_q : a;
  // rst_n is folded in so the request handshake is closed while reset is held
  assign in_ready  = rst_n && (state_q == ST_IDLE) && !mul_busy && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_e == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (opa),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    sum     = '0;
    alu_res = '0;
    c_bit   = 1'b0;
    v_bit   = 1'b0;
    case (op_e)
      OP_ADD: begin
        sum     = {1'b0, opa} + {1'b0, b} + (WIDTH+1)'(cin);
        alu_res = sum[WIDTH-1:0];
        c_bit   = sum[WIDTH];
        v_bit   = (opa[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, opa} + {1'b0, ~b} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        c_bit   = sum[WIDTH];
        v_bit   = (opa[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND: alu_res = opa & b;
      OP_OR:  alu_res = opa | b;
      OP_XOR: alu_res = opa ^ b;
      OP_SHL: begin
        alu_res = {opa[WIDTH-2:0], 1'b0};
        c_bit   = opa[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, opa[WIDTH-1:1]};
        c_bit   = opa[0];
      end
      default: ;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_V] = v_bit;
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = c_bit;
  end

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_prod[2*WIDTH-1];
    mul_flags[FLAG_Z] = (mul_prod == '0);
    mul_flags[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      if (out_ready) out_valid_q <= 1'b0;
      if (mul_done) begin
        state_q     <= ST_IDLE;
        out_valid_q <= 1'b1;
        result_q    <= mul_prod[WIDTH-1:0];
        result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
        flags_q     <= mul_flags;
      end else if (mul_start) begin
        state_q <= ST_BUSY;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res;
        result_hi_q <= '0;
        flags_q     <= alu_flags;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe_core.sv
// Scoreboard bench for alu_pipe_core at WIDTH = 8: directed corner cases, then random traffic.
module tb_alu_pipe_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic         acc_sel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;

  always #5 clk = ~clk;

  alu_pipe_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .acc_sel   (acc_sel),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   flg;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         rnd_rdy = 1'b0;
  logic [W-1:0] acc_model = '0;

  // Reference: plain integer arithmetic on the opcode definitions; flags are {V,N,Z,C}.
  function automatic exp_t model(int opc, int av, int bv, int ci);
    longint m = longint'(1) << W;
    longint p = 0;
    longint r = 0;
    longint hi = 0;
    longint sa, sb, ss;
    bit c = 0, v = 0, z, n;
    exp_t e;
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    case (opc)
      0: begin p = av + bv + ci; r = p % m; c = (p >= m);
               ss = sa + sb + ci; v = (ss >= m / 2) || (ss < -(m / 2)); end
      1: begin p = av + (m - 1 - bv) + 1; r = p % m; c = (p >= m);
               ss = sa - sb; v = (ss >= m / 2) || (ss < -(m / 2)); end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: begin r = (av * 2) % m; c = (av >= m / 2); end
      6: begin r = av / 2; c = (av % 2) == 1; end
      default: begin p = longint'(av) * longint'(bv); r = p % m; hi = p / m; c = (hi != 0); end
    endcase
    z = (opc == 7) ? (p == 0) : (r == 0);
    n = (opc == 7) ? (hi >= m / 2) : (r >= m / 2);
    e.res = W'(r);
    e.hi  = W'(hi);
    e.flg = {v, n, z, c};
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic sel, output int waits);
    bit   got;
    exp_t e;
    op = o; a = av; b = bv; cin = ci; acc_sel = sel; in_valid = 1'b1;
    waits = 0;
    got = 0;
    while (!got && waits <= 300) begin
      @(negedge clk);
      if (in_ready) got = 1;
      else begin
        waits++;
        tick();
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: request op %0d not accepted within 300 cycles", o);
    end else begin
      e = model(int'(o), int'(sel ? acc_model : av), int'(bv), int'(ci));
      exp_q.push_back(e);
      acc_model = e.res;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per consumed result, and checks stability while stalled.
  initial begin : monitor
    bit   stall = 0;
    exp_t held;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (stall) check("stall_stable", {result, result_hi, flags}, held);
        if (out_ready) begin
          stall = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: result 0x%0h with empty scoreboard", result);
          end else begin
            e = exp_q.pop_front();
            check("sb_result",    result,    e.res);
            check("sb_result_hi", result_hi, e.hi);
            check("sb_flags",     flags,     e.flg);
          end
        end else begin
          stall = 1;
          held  = {result, result_hi, flags};
        end
      end else begin
        stall = 0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int  w;
    bit  seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; cin = 1'b0; acc_sel = 1'b0;

    repeat (3) tick();
    @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", {result, result_hi, flags}, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    tick();

    out_ready = 1'b1;
    send(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0, w);   // ADD wraps to zero with carry
    send(3'b001, 8'h80, 8'h01, 1'b0, 1'b0, w);   // SUB signed overflow

    send(3'b111, 8'hFF, 8'hFF, 1'b0, 1'b0, w);
    for (int k = 1; k <= W; k++) begin
      tick();
      if (k < W) begin
        check("mul_busy_in_ready", in_ready, 0);
        check("mul_early_valid", out_valid, 0);
      end else begin
        check("mul_latency_valid", out_valid, 1);
      end
    end
    tick();

    // Backpressure: second request must wait, then go in on the consuming edge.
    out_ready = 1'b0;
    send(3'b000, 8'd5, 8'd3, 1'b0, 1'b0, w);
    op = 3'b000; a = 8'd1; b = 8'd1; cin = 1'b0; acc_sel = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, 8'h08);
      tick();
    end
    out_ready = 1'b1;
    send(3'b000, 8'd1, 8'd1, 1'b0, 1'b0, w);
    check("bp_accept_same_edge", w, 0);

    send(3'b000, 8'd5, 8'd3, 1'b0, 1'b0, w);
    send(3'b000, 8'hA5, 8'd2, 1'b0, 1'b1, w);   // accumulator feedback: 8 + 2
    repeat (2) tick();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), w);
      if ($urandom_range(0, 3) == 0) tick();
    end

    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    check("drain_empty", exp_q.size(), 0);

    // Reset in the middle of a multiply must abort it silently.
    send(3'b111, 8'h37, 8'h9B, 1'b0, 1'b0, w);
    repeat (3) tick();
    rst_n = 1'b0;
    exp_q.delete();
    acc_model = '0;
    @(negedge clk);
    check("abort_reset_in_ready", in_ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_outputs", {result, result_hi, flags}, 0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("abort_no_pulse", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
